gpu_fb_ctrl: RTL
================

// Module: gpu_fb_ctrl
// PURPOSE
//  Parametrised successor of the GPU top: framebuffer RAM, VGA timing, scaled scan-out and CPU write port in one block.
//  - CPU writes PIX_W-bit pixels by linear address.
//  - Scan-out replicates each pixel 2^SCALE_LOG2 times in x and y and expands RGB332 to 12-bit RGB.
//  - Adds a pixel-clock divider, frame/vblank status and a write-ready handshake.
//  - An optional hardware clear engine fills the framebuffer with one colour.
// PARAMETERS
//  FB_W       160  framebuffer width, pixels
//  FB_H       120  framebuffer height, pixels
//  SCALE_LOG2 2    log2 of the replication factor; FB_W<<SCALE_LOG2 must equal H_VIS
//  PIX_W      8    bits per pixel; RGB332 layout when 8
//  ADDR_W     15   framebuffer address width, >= clog2(FB_W*FB_H)
//  CLK_DIV    4    clk cycles per VGA pixel; must be >=3
//  H_VIS/H_FP/H_SYNC/H_BP  640/16/96/48  horizontal timing, in pixels
//  V_VIS/V_FP/V_SYNC/V_BP  480/10/2/33   vertical timing, in lines
// PORTS
//  clk          in  1       system clock; sole clock domain
//  rst          in  1       synchronous, active-high reset
//  v_we_i       in  1       CPU write strobe; accepted only when v_ready_o=1
//  v_addr_i     in  ADDR_W  CPU linear pixel address (y*FB_W+x)
//  v_data_i     in  PIX_W   CPU pixel data
//  v_ready_o    out 1       1 = CPU write port can accept a write
//  clr_start_i  in  1       start a clear (clear engine only)
//  clr_color_i  in  PIX_W   fill colour, sampled on the start cycle
//  clr_busy_o   out 1       clear in progress
//  frame_o      out 1       1-clk pulse when the scan counters wrap to (0,0)
//  vblank_o     out 1       1 while vcnt >= V_VIS
//  Hsync, Vsync out 1 each  active-low syncs
//  vgaRed, vgaGreen, vgaBlue  out 4 each  colour outputs
// BEHAVIOUR
//  - Reset: all counters 0; Hsync=Vsync=1; RGB=0; frame_o=0; vblank_o=0; clr_busy_o=0; v_ready_o=1; FSM=IDLE.
//    RAM contents are not reset. A reset during a clear aborts it; pixels already written keep their colour.
//  - Divider: pix_en pulses for one clk every CLK_DIV clks.
//    On pix_en, hcnt wraps at H_TOT-1 (H_TOT = sum of the H_* parameters).
//    vcnt increments when hcnt wraps and itself wraps at V_TOT-1.
//  - frame_o pulses on the clk where both counters become 0.
//  - Scan pipeline:
//    - Counters update on pix_en (cycle P).
//    - The read address (vcnt>>SCALE_LOG2)*FB_W + (hcnt>>SCALE_LOG2) is registered at P+1.
//    - RAM data is valid at P+2 (synchronous read, 1-clk latency).
//    - The RGB registers load at the next pix_en.
//    - Hsync, Vsync and the visibility flag pass through a matching delay.
//    - All outputs therefore lag the counters by exactly one pixel period.
//  - Sync and blanking:
//    - Hsync=0 when H_VIS+H_FP <= hcnt < H_VIS+H_FP+H_SYNC; Vsync is defined the same way on vcnt.
//    - Outside hcnt<H_VIS && vcnt<V_VIS, RGB=0 and the RAM read enable is low.
//  - Colour expansion:
//    - R = {p[7:5], p[7]}
//    - G = {p[4:2], p[4]}
//    - B = {p[1:0], p[1:0]}
//  - CPU writes:
//    - Write on the clk where v_we_i && v_ready_o. Data is visible to scan-out from the next clk.
//    - Addresses >= FB_W*FB_H are dropped; no wrap and no alias.
//    - Read and write to the same address in one clk: the read returns the old data (read-first).
//    - Writes with v_ready_o=0 are dropped; the CPU must poll ready.
//  - Clear FSM:
//    - IDLE -> FILL on clr_start_i: latch the colour, set addr=0, clr_busy_o=1, v_ready_o=0.
//    - FILL writes one pixel per clk to addresses 0..FB_W*FB_H-1.
//    - After the last write the FSM returns to IDLE on the next clk; busy=0 and ready=1 that same clk.
//    - A clear takes exactly FB_W*FB_H clks of busy.
//    - clr_start_i while busy is ignored; start and v_we_i in the same IDLE clk: the CPU write lands, then the clear begins.
//    - Scan-out continues during a clear and may show a partial fill.
// CONFIGURATION
//  GPU_CLEAR_EN defined:     clear FSM present as described above.
//  GPU_CLEAR_EN not defined: no FSM; clr_start_i and clr_color_i ignored; clr_busy_o=0 and v_ready_o=1 constant.
//  Ports exist in both builds.
// TESTING
//  1. Reset, then run 2 frames with defaults -> Hsync low 96 px per 800-px line; Vsync low 2 lines per 525; frame_o every 800*525*4 clk.
//  2. Write 0xE0 to addr 0 and 0x03 to addr 161 -> screen (0..3,0..3) RGB=F,0,0; screen (4..7,4..7) RGB=0,0,F; blanking is 0.
//  3. Write 0xFF to addr 19200 -> RAM unchanged; rescan of addr 0 and addr 19199 shows the previous values.
//  4. GPU_CLEAR_EN: start with colour 0x1C -> busy exactly 19200 clk, ready=0 for that whole span, all pixels G=F; a mid-clear write is dropped.
//  5. GPU_CLEAR_EN: reset asserted at clear clk 100 -> busy=0 the next clk; addrs 0..99 cleared, addr 100 unchanged.
//  6. GPU_CLEAR_EN undefined: pulse clr_start_i -> clr_busy_o stays 0, v_ready_o stays 1, RAM unchanged.

Source files
------------

// File: rtl/gpu_fb_ctrl.sv
// gpu_fb_ctrl: framebuffer RAM, VGA timing generator, scaled scan-out and a CPU
// write port. Each framebuffer pixel is replicated 2^SCALE_LOG2 times in x and y
// and RGB332 is expanded to 12-bit RGB.
// Optional hardware clear engine: define GPU_CLEAR_EN to include it.
module gpu_fb_ctrl #(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int SCALE_LOG2 = 2,
    parameter int PIX_W      = 8,
    parameter int ADDR_W     = 15,
    parameter int CLK_DIV    = 4,
    parameter int H_VIS      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIS      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              v_we_i,
    input  logic [ADDR_W-1:0] v_addr_i,
    input  logic [PIX_W-1:0]  v_data_i,
    output logic              v_ready_o,
    input  logic              clr_start_i,
    input  logic [PIX_W-1:0]  clr_color_i,
    output logic              clr_busy_o,
    output logic              frame_o,
    output logic              vblank_o,
    output logic              Hsync,
    output logic              Vsync,
    output logic [3:0]        vgaRed,
    output logic [3:0]        vgaGreen,
    output logic [3:0]        vgaBlue
);
    localparam int FB_SIZE = FB_W * FB_H;
    localparam int IDX_W   = $clog2(FB_SIZE);
    localparam int H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOT);
    localparam int VC_W    = $clog2(V_TOT);
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [HC_W-1:0]  H_LAST     = HC_W'(H_TOT - 1);
    localparam logic [HC_W-1:0]  H_VIS_C    = HC_W'(H_VIS);
    localparam logic [HC_W-1:0]  H_SYNC_BEG = HC_W'(H_VIS + H_FP);
    localparam logic [HC_W-1:0]  H_SYNC_END = HC_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [VC_W-1:0]  V_LAST     = VC_W'(V_TOT - 1);
    localparam logic [VC_W-1:0]  V_VIS_C    = VC_W'(V_VIS);
    localparam logic [VC_W-1:0]  V_SYNC_BEG = VC_W'(V_VIS + V_FP);
    localparam logic [VC_W-1:0]  V_SYNC_END = VC_W'(V_VIS + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_reg;
    logic [HC_W-1:0]  hcnt_reg;
    logic [VC_W-1:0]  vcnt_reg;
    logic             frame_reg;
    logic             pix_en;
    logic             h_wrap;
    logic             v_wrap;

    assign pix_en   = (div_reg == DIV_LAST);
    assign h_wrap   = (hcnt_reg == H_LAST);
    assign v_wrap   = (vcnt_reg == V_LAST);
    assign frame_o  = frame_reg;
    assign vblank_o = (vcnt_reg >= V_VIS_C);

    // Pixel-clock divider and raster counters; frame pulse when both wrap to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg   <= '0;
            hcnt_reg  <= '0;
            vcnt_reg  <= '0;
            frame_reg <= 1'b0;
        end else begin
            frame_reg <= 1'b0;
            div_reg   <= pix_en ? '0 : div_reg + DIV_W'(1);
            if (pix_en) begin
                hcnt_reg <= h_wrap ? '0 : hcnt_reg + HC_W'(1);
                if (h_wrap) begin
                    vcnt_reg  <= v_wrap ? '0 : vcnt_reg + VC_W'(1);
                    frame_reg <= v_wrap;
                end
            end
        end
    end

    // Scan stage 1: read address, visibility and syncs of the current counters.
    logic [IDX_W-1:0] rd_addr_reg;
    logic             vis_reg;
    logic             hs_reg;
    logic             vs_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_reg <= '0;
            vis_reg     <= 1'b0;
            hs_reg      <= 1'b1;
            vs_reg      <= 1'b1;
        end else begin
            rd_addr_reg <= IDX_W'(32'(vcnt_reg >> SCALE_LOG2) * 32'(FB_W)
                                  + 32'(hcnt_reg >> SCALE_LOG2));
            vis_reg     <= (hcnt_reg < H_VIS_C) && (vcnt_reg < V_VIS_C);
            hs_reg      <= !((hcnt_reg >= H_SYNC_BEG) && (hcnt_reg < H_SYNC_END));
            vs_reg      <= !((vcnt_reg >= V_SYNC_BEG) && (vcnt_reg < V_SYNC_END));
        end
    end

    // Write port arbitration between the CPU and the clear engine.
    logic             cpu_we;
    logic             clr_we;
    logic [IDX_W-1:0] clr_addr;
    logic [PIX_W-1:0] clr_color;
    logic             ram_we;
    logic [IDX_W-1:0] ram_waddr;
    logic [PIX_W-1:0] ram_wdata;

    // Out-of-range addresses are dropped rather than wrapped.
    assign cpu_we    = v_we_i && v_ready_o && (32'(v_addr_i) < 32'(FB_SIZE));
    // Reset suppresses any write in flight so an aborted clear stops cleanly.
    assign ram_we    = !rst && (cpu_we || clr_we);
    assign ram_waddr = clr_we ? clr_addr : v_addr_i[IDX_W-1:0];
    assign ram_wdata = clr_we ? clr_color : v_data_i;

`ifdef GPU_CLEAR_EN
    typedef enum logic {IDLE, FILL} state_t;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FB_SIZE - 1);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] clr_addr_reg, clr_addr_next;
    logic [PIX_W-1:0] clr_color_reg, clr_color_next;

    // Clear engine state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            clr_addr_reg  <= '0;
            clr_color_reg <= '0;
        end else begin
            state_reg     <= state_next;
            clr_addr_reg  <= clr_addr_next;
            clr_color_reg <= clr_color_next;
        end
    end

    // Clear engine next state: one pixel per clk from address 0 to the last.
    always_comb begin
        state_next     = state_reg;
        clr_addr_next  = clr_addr_reg;
        clr_color_next = clr_color_reg;
        clr_we         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (clr_start_i) begin
                    state_next     = FILL;
                    clr_addr_next  = '0;
                    clr_color_next = clr_color_i;
                end
            end
            FILL: begin
                clr_we        = 1'b1;
                clr_addr_next = clr_addr_reg + IDX_W'(1);
                if (clr_addr_reg == LAST_IDX) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign clr_addr   = clr_addr_reg;
    assign clr_color  = clr_color_reg;
    assign clr_busy_o = (state_reg == FILL);
    assign v_ready_o  = (state_reg == IDLE);
`else
    logic unused_clr;

    assign unused_clr = clr_start_i ^ (^clr_color_i);
    assign clr_we     = 1'b0;
    assign clr_addr   = '0;
    assign clr_color  = '0;
    assign clr_busy_o = 1'b0;
    assign v_ready_o  = 1'b1;
`endif

    // Framebuffer RAM: registered read (read-first), read enabled only when visible.
    logic [PIX_W-1:0] mem [FB_SIZE];
    logic [PIX_W-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        if (vis_reg) begin
            rd_data_reg <= mem[rd_addr_reg];
        end
    end

    // Colour expansion treats the pixel as RGB332.
    logic [7:0] pix8;
    assign pix8 = 8'(rd_data_reg);

    // Output stage: load colour and syncs on the next pixel tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            Hsync    <= 1'b1;
            Vsync    <= 1'b1;
            vgaRed   <= '0;
            vgaGreen <= '0;
            vgaBlue  <= '0;
        end else if (pix_en) begin
            Hsync <= hs_reg;
            Vsync <= vs_reg;
            if (vis_reg) begin
                vgaRed   <= {pix8[7:5], pix8[7]};
                vgaGreen <= {pix8[4:2], pix8[4]};
                vgaBlue  <= {pix8[1:0], pix8[1:0]};
            end else begin
                vgaRed   <= '0;
                vgaGreen <= '0;
                vgaBlue  <= '0;
            end
        end
    end
endmodule
